// File: rtl/pq_deq_drain.sv
// -----------------------------------------------------------------------------
// pq_pkg / pq_deq_drain
//
// pq_pkg holds the default key/value widths shared by the priority-queue
// blocks and the drain controller's state encoding.
//
// pq_deq_drain is the consumer side of the shared priority-queue interface.
// It issues pq_deq and moves each head entry pq_kvo into a 2-entry output
// FIFO that feeds a valid/ready stream. It drains in two modes: continuously
// while cont_en is high, or for a counted burst started from IDLE. It also
// watches key ordering: between enqueues, dequeued keys must not decrease.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   pq_kvo          PQ head entry {key,val}, valid while pq_empty==0
//   pq_empty        PQ empty flag
//   pq_enq          observed PQ enqueue strobe (ordering monitor only)
//   pq_deq          dequeue strobe to the PQ (combinational)
//   cont_en         continuous drain enable
//   burst_start     start a counted burst (pulse, honoured in IDLE only)
//   burst_len       entries to drain in the burst; 0 is a no-op
//   m_valid/m_ready/m_kv  output stream
//   busy            controller not in IDLE
//   done            one-cycle pulse after the last dequeue of a burst
//   order_err       sticky ordering violation
//   drained         entries dequeued since reset (wraps)
// -----------------------------------------------------------------------------
package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONT  = 2'd1,
        ST_BURST = 2'd2
    } drain_state_e;
endpackage

module pq_deq_drain #(
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter int CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo,
    input  logic                           pq_empty,
    input  logic                           pq_enq,
    output logic                           pq_deq,
    input  logic                           cont_en,
    input  logic                           burst_start,
    input  logic [CNT_WIDTH-1:0]           burst_len,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] m_kv,
    output logic                           busy,
    output logic                           done,
    output logic                           order_err,
    output logic [CNT_WIDTH-1:0]           drained
);

    localparam int KVW = KEY_WIDTH + VAL_WIDTH;

    pq_pkg::drain_state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [1:0]           occ_q, occ_d;
    logic [KVW-1:0]       head_q, head_d;
    logic [KVW-1:0]       tail_q, tail_d;
    logic [KEY_WIDTH-1:0] last_key_q, last_key_d;
    logic                 last_valid_q, last_valid_d;
    logic                 enq_seen_q, enq_seen_d;
    logic                 order_err_q, order_err_d;
    logic [CNT_WIDTH-1:0] drained_q, drained_d;
    logic                 done_q, done_d;

    logic                 pop;
    logic                 space;
    logic                 drain_active;
    logic [KEY_WIDTH-1:0] head_key;

    assign head_key = pq_kvo[KVW-1:VAL_WIDTH];
    assign pop      = m_valid && m_ready;
    // A full buffer still has room when its head leaves in this same cycle.
    assign space    = (occ_q < 2'd2) || pop;
    assign drain_active = (state_q == pq_pkg::ST_CONT) ||
                          ((state_q == pq_pkg::ST_BURST) && (remaining_q != '0));
    assign pq_deq   = drain_active && !pq_empty && space;

    assign m_valid   = (occ_q != 2'd0);
    assign m_kv      = head_q;
    assign busy      = (state_q != pq_pkg::ST_IDLE);
    assign done      = done_q;
    assign order_err = order_err_q;
    assign drained   = drained_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d      = state_q;
        remaining_d  = remaining_q;
        occ_d        = occ_q;
        head_d       = head_q;
        tail_d       = tail_q;
        last_key_d   = last_key_q;
        last_valid_d = last_valid_q;
        enq_seen_d   = enq_seen_q;
        order_err_d  = order_err_q;
        drained_d    = drained_q;
        done_d       = 1'b0;

        // Output FIFO: head_q is the stream register, tail_q the overflow slot.
        unique case ({pq_deq, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = pq_kvo;
                else               tail_d = pq_kvo;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) head_d = tail_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = pq_kvo;
                end else begin
                    head_d = tail_q;
                    tail_d = pq_kvo;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            pq_pkg::ST_IDLE: begin
                if (burst_start && (burst_len != '0)) begin
                    state_d     = pq_pkg::ST_BURST;
                    remaining_d = burst_len;
                end else if (cont_en) begin
                    state_d = pq_pkg::ST_CONT;
                end
            end
            pq_pkg::ST_CONT: begin
                if (!cont_en) state_d = pq_pkg::ST_IDLE;
            end
            pq_pkg::ST_BURST: begin
                if (pq_deq) begin
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = pq_pkg::ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = pq_pkg::ST_IDLE;
        endcase

        // Ordering monitor: a pending enqueue may legally insert a smaller key,
        // so the comparison is skipped for the first dequeue after one.
        if (pq_deq) begin
            if (last_valid_q && !enq_seen_q && (head_key < last_key_q))
                order_err_d = 1'b1;
            last_key_d   = head_key;
            last_valid_d = 1'b1;
            drained_d    = drained_q + CNT_WIDTH'(1);
        end
        if (pq_enq)      enq_seen_d = 1'b1;
        else if (pq_deq) enq_seen_d = 1'b0;
    end

    // NOTE: the two buffer slots are cleared on reset like any other state so
    // m_kv reads zero after reset and a mid-burst reset leaves nothing behind.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples the
        // pre-edge value of its _d regardless of statement order.
        if (!rst_n) begin
            state_q      <= pq_pkg::ST_IDLE;
            remaining_q  <= '0;
            occ_q        <= 2'd0;
            head_q       <= '0;
            tail_q       <= '0;
            last_key_q   <= '0;
            last_valid_q <= 1'b0;
            enq_seen_q   <= 1'b0;
            order_err_q  <= 1'b0;
            drained_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            last_key_q   <= last_key_d;
            last_valid_q <= last_valid_d;
            enq_seen_q   <= enq_seen_d;
            order_err_q  <= order_err_d;
            drained_q    <= drained_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_pq_deq_drain.sv
// -----------------------------------------------------------------------------
// Testbench for pq_deq_drain. A behavioural priority queue (an unordered
// queue whose head is its smallest {key,val}) feeds the DUT; every entry the
// DUT dequeues is appended to an expected-stream queue that the output
// stream must reproduce in order. The ordering flag, drained count and
// burst/mode behaviour are checked against rules computed in the bench.
// -----------------------------------------------------------------------------
module tb_pq_deq_drain;

    localparam int KW = pq_pkg::KEY_WIDTH;
    localparam int VW = pq_pkg::VAL_WIDTH;
    localparam int CW = 8;
    localparam int W  = KW + VW;

    typedef logic [W-1:0] kv_t;

    logic          clk = 1'b0;
    logic          rst_n;
    kv_t           pq_kvo;
    logic          pq_empty;
    logic          pq_enq;
    logic          pq_deq;
    logic          cont_en;
    logic          burst_start;
    logic [CW-1:0] burst_len;
    logic          m_valid;
    logic          m_ready;
    kv_t           m_kv;
    logic          busy;
    logic          done;
    logic          order_err;
    logic [CW-1:0] drained;

    kv_t           enq_kv;

    always #5 clk = ~clk;

    pq_deq_drain #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pq_kvo     (pq_kvo),
        .pq_empty   (pq_empty),
        .pq_enq     (pq_enq),
        .pq_deq     (pq_deq),
        .cont_en    (cont_en),
        .burst_start(burst_start),
        .burst_len  (burst_len),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_kv       (m_kv),
        .busy       (busy),
        .done       (done),
        .order_err  (order_err),
        .drained    (drained)
    );

    int errors = 0;
    int checks = 0;

    kv_t pq_m[$];     // behavioural PQ contents
    kv_t exp_q[$];    // entries dequeued but not yet seen on the stream
    kv_t out_log[$];  // entries seen on the stream

    logic [CW-1:0] m_drained;
    logic          m_err;
    logic          m_last_valid;
    logic          m_enq_seen;
    logic [KW-1:0] m_last_key;

    int deq_cnt;
    int done_cnt;
    int valid_cnt;

    function automatic kv_t mk(input int k, input int v);
        kv_t r;
        r = {k[KW-1:0], v[VW-1:0]};
        return r;
    endfunction

    function automatic int min_idx();
        int idx = 0;
        for (int i = 1; i < pq_m.size(); i++)
            if (pq_m[i] < pq_m[idx]) idx = i;
        return idx;
    endfunction

    task automatic update_pq();
        pq_empty = (pq_m.size() == 0);
        pq_kvo   = pq_empty ? '0 : pq_m[min_idx()];
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_drained    = '0;
        m_err        = 1'b0;
        m_last_valid = 1'b0;
        m_enq_seen   = 1'b0;
        m_last_key   = '0;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        pq_enq      = 1'b0;
        burst_start = 1'b0;
        burst_len   = '0;
        cont_en     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: sample mid-cycle, score the stream, advance the model
    // PQ across the edge, then compare the counters and the ordering flag.
    task automatic tick();
        logic          d;
        logic          e;
        logic [KW-1:0] k;
        int            idx;
        #1;
        d = pq_deq;
        e = pq_enq;
        if (d && pq_empty) begin
            errors++;
            $display("FAIL deq_on_empty: pq_deq=%0b while pq_empty=1", d);
        end
        if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got %h with nothing expected", m_kv);
            end else begin
                if (m_kv !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stream_data: got %h expected %h", m_kv, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            out_log.push_back(m_kv);
        end
        if (done)    done_cnt++;
        if (m_valid) valid_cnt++;
        if (d) begin
            deq_cnt++;
            k = pq_kvo[W-1:VW];
            if (m_last_valid && !m_enq_seen && k < m_last_key) m_err = 1'b1;
            m_last_key   = k;
            m_last_valid = 1'b1;
            exp_q.push_back(pq_kvo);
            m_drained = m_drained + 1'b1;
        end
        if (e)      m_enq_seen = 1'b1;
        else if (d) m_enq_seen = 1'b0;

        @(posedge clk); #1;
        if (d) begin
            idx = min_idx();
            pq_m.delete(idx);
        end
        if (e) pq_m.push_back(enq_kv);
        update_pq();

        checks++;
        if (drained !== m_drained) begin
            errors++;
            $display("FAIL drained_count: got %0d expected %0d", drained, m_drained);
        end
        checks++;
        if (order_err !== m_err) begin
            errors++;
            $display("FAIL order_err_model: got %0b expected %0b", order_err, m_err);
        end
    endtask

    task automatic test_reset();
        pq_m.delete();
        pq_m.push_back(mk(3, 3));
        update_pq();
        cont_en     = 1'b1;
        m_ready     = 1'b1;
        burst_start = 1'b0;
        burst_len   = '0;
        pq_enq      = 1'b0;
        enq_kv      = '0;
        rst_n       = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (pq_deq !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: pq_deq=%0b m_valid=%0b expected 0 0", pq_deq, m_valid);
            end
            checks++;
            if (drained !== '0 || order_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_status: drained=%0d order_err=%0b expected 0 0", drained, order_err);
            end
            checks++;
            if (busy !== 1'b0 || m_kv !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: busy=%0b m_kv=%h done=%0b expected 0 0 0", busy, m_kv, done);
            end
            @(posedge clk); #1;
        end
        rst_n   = 1'b1;
        cont_en = 1'b0;
        model_reset();
        pq_m.delete();
        update_pq();
    endtask

    task automatic test_burst_stall();
        kv_t want[4];
        want[0] = mk(1, 11);
        want[1] = mk(8, 14);
        want[2] = mk(9, 10);
        want[3] = mk(9, 11);
        apply_reset();
        pq_m.delete();
        pq_m.push_back(mk(8, 14));
        pq_m.push_back(mk(9, 10));
        pq_m.push_back(mk(9, 11));
        pq_m.push_back(mk(9, 12));
        pq_m.push_back(mk(1, 11));
        update_pq();
        m_ready = 1'b1;
        out_log.delete();
        deq_cnt = 0;
        done_cnt = 0;
        burst_len   = 8'd4;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        burst_len   = '0;
        #1;
        checks++;
        if (pq_deq !== 1'b1) begin
            errors++;
            $display("FAIL burst_first_deq: pq_deq=%0b expected 1", pq_deq);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_kv !== want[0]) begin
            errors++;
            $display("FAIL burst_latency: m_valid=%0b m_kv=%h expected 1 %h", m_valid, m_kv, want[0]);
        end
        repeat (10) tick();
        checks++;
        if (out_log.size() != 4) begin
            errors++;
            $display("FAIL burst_count: got %0d entries expected 4", out_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_log[i] !== want[i]) begin
                    errors++;
                    $display("FAIL burst_seq%0d: got %h expected %h", i, out_log[i], want[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL burst_done: %0d pulses expected 1", done_cnt);
        end
        checks++;
        if (drained !== 8'd4 || pq_m.size() != 1 || pq_empty !== 1'b0) begin
            errors++;
            $display("FAIL burst_left: drained=%0d left=%0d expected 4 1", drained, pq_m.size());
        end
        checks++;
        if (order_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: order_err=%0b busy=%0b expected 0 0", order_err, busy);
        end
    endtask

    task automatic test_backpressure();
        kv_t ins[$];
        kv_t held;
        apply_reset();
        pq_m.delete();
        for (int i = 0; i < 5; i++) begin
            kv_t e;
            e = mk($urandom_range(0, 200), $urandom_range(0, 255));
            pq_m.push_back(e);
            ins.push_back(e);
        end
        ins.sort();
        update_pq();
        m_ready = 1'b0;
        cont_en = 1'b1;
        deq_cnt = 0;
        out_log.delete();
        repeat (8) tick();
        held = m_kv;
        checks++;
        if (deq_cnt != 2 || pq_deq !== 1'b0) begin
            errors++;
            $display("FAIL bp_deqs: %0d deqs pq_deq=%0b expected 2 0", deq_cnt, pq_deq);
        end
        repeat (3) tick();
        checks++;
        if (m_valid !== 1'b1 || m_kv !== held || m_kv !== ins[0]) begin
            errors++;
            $display("FAIL bp_hold: m_kv=%h m_valid=%0b expected %h 1", m_kv, m_valid, ins[0]);
        end
        m_ready   = 1'b1;
        valid_cnt = 0;
        repeat (5) tick();
        checks++;
        if (valid_cnt != 5) begin
            errors++;
            $display("FAIL bp_rate: %0d valid cycles expected 5", valid_cnt);
        end
        cont_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_log.size() != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_total: %0d entries busy=%0b expected 5 0", out_log.size(), busy);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (out_log[i] !== ins[i]) begin
                    errors++;
                    $display("FAIL bp_seq%0d: got %h expected %h", i, out_log[i], ins[i]);
                end
            end
        end
    endtask

    task automatic test_empty_stall();
        apply_reset();
        pq_m.delete();
        pq_m.push_back(mk(10, 5));
        update_pq();
        m_ready  = 1'b1;
        deq_cnt  = 0;
        done_cnt = 0;
        burst_len   = 8'd3;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        burst_len   = '0;
        repeat (4) tick();
        checks++;
        if (deq_cnt != 1 || busy !== 1'b1 || pq_deq !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait: deqs=%0d busy=%0b pq_deq=%0b expected 1 1 0", deq_cnt, busy, pq_deq);
        end
        pq_enq = 1'b1;
        enq_kv = mk(11, 1);
        tick();
        pq_enq = 1'b0;
        repeat (3) tick();
        checks++;
        if (deq_cnt != 2 || busy !== 1'b1 || done_cnt != 0) begin
            errors++;
            $display("FAIL stall_resume: deqs=%0d busy=%0b done=%0d expected 2 1 0", deq_cnt, busy, done_cnt);
        end
        pq_enq = 1'b1;
        enq_kv = mk(4, 1);
        tick();
        pq_enq = 1'b0;
        repeat (4) tick();
        checks++;
        if (deq_cnt != 3 || done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_finish: deqs=%0d done=%0d busy=%0b expected 3 1 0", deq_cnt, done_cnt, busy);
        end
        checks++;
        if (order_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_order: order_err=%0b expected 0", order_err);
        end
    endtask

    task automatic test_mode_edges();
        apply_reset();
        pq_m.delete();
        for (int i = 0; i < 4; i++) pq_m.push_back(mk(20 + i, i));
        update_pq();
        m_ready  = 1'b0;
        deq_cnt  = 0;
        done_cnt = 0;
        out_log.delete();
        burst_len   = '0;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || deq_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL len0_noop: busy=%0b deqs=%0d done=%0d expected 0 0 0", busy, deq_cnt, done_cnt);
        end
        cont_en = 1'b1;
        repeat (6) tick();
        checks++;
        if (deq_cnt != 2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_fill: deqs=%0d busy=%0b expected 2 1", deq_cnt, busy);
        end
        burst_len   = 8'd3;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        burst_len   = '0;
        cont_en     = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_in_cont: busy=%0b expected 0", busy);
        end
        m_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (out_log.size() != 2 || deq_cnt != 2 || pq_m.size() != 2 || done_cnt != 0) begin
            errors++;
            $display("FAIL cont_drop_drain: out=%0d deqs=%0d left=%0d done=%0d expected 2 2 2 0",
                     out_log.size(), deq_cnt, pq_m.size(), done_cnt);
        end
    endtask

    task automatic test_order_fault();
        apply_reset();
        pq_m.delete();
        pq_m.push_back(mk(5, 1));
        update_pq();
        m_ready = 1'b1;
        cont_en = 1'b1;
        deq_cnt = 0;
        tick();
        tick();
        checks++;
        if (deq_cnt != 1 || order_err !== 1'b0) begin
            errors++;
            $display("FAIL fault_first: deqs=%0d order_err=%0b expected 1 0", deq_cnt, order_err);
        end
        // A faulty PQ presents a smaller key without any enqueue.
        pq_m.push_back(mk(3, 2));
        update_pq();
        tick();
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL fault_flag: order_err=%0b expected 1", order_err);
        end
        cont_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: order_err=%0b expected 1", order_err);
        end
        apply_reset();
        #1;
        checks++;
        if (order_err !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: order_err=%0b expected 0", order_err);
        end
    endtask

    task automatic test_random();
        int guard;
        apply_reset();
        pq_m.delete();
        update_pq();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) cont_en = ~cont_en;
            burst_start = ($urandom_range(0, 15) == 0);
            burst_len   = CW'($urandom_range(0, 5));
            pq_enq      = ($urandom_range(0, 3) == 0);
            enq_kv      = mk($urandom_range(0, 63), $urandom_range(0, 255));
            m_ready     = ($urandom_range(0, 3) != 0);
            tick();
        end
        cont_en     = 1'b0;
        burst_start = 1'b0;
        burst_len   = '0;
        m_ready     = 1'b1;
        guard       = 0;
        while ((busy || m_valid) && guard < 300) begin
            pq_enq = pq_empty && busy;
            enq_kv = mk($urandom_range(0, 63), 0);
            tick();
            guard++;
        end
        pq_enq = 1'b0;
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: busy=%0b undelivered=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pq_enq      = 1'b0;
        cont_en     = 1'b0;
        burst_start = 1'b0;
        burst_len   = '0;
        m_ready     = 1'b0;
        enq_kv      = '0;
        deq_cnt     = 0;
        done_cnt    = 0;
        valid_cnt   = 0;
        model_reset();
        update_pq();
        test_reset();
        test_burst_stall();
        test_backpressure();
        test_empty_stall();
        test_mode_edges();
        test_order_fault();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
